// File: rtl/melee_attack_ctl.sv
`timescale 1ns/1ps
// melee_attack_ctl: turns a raw mouse-button level into one frame-paced weapon
// swing (out, then back) followed by a cooldown window, and drives the
// weapon drawer's enable, horizontal offset and latched facing.
module melee_attack_ctl #(
    parameter int unsigned SWING_STEP      = 4,
    parameter int unsigned SWING_MAX       = 24,
    parameter int unsigned COOLDOWN_FRAMES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        mouse_left,
    input  logic        flip_in,
    output logic        attack_active,
    output logic [11:0] anim_x_offset,
    output logic        flip_hor_melee,
    output logic        hit_pulse,
    output logic        busy
);

    localparam int unsigned OFF_W = 12;
    localparam int unsigned SUM_W = OFF_W + 1;
    localparam int unsigned CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWING_OUT  = 2'd1,
        SWING_BACK = 2'd2,
        COOLDOWN   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [OFF_W-1:0]   offset_q, offset_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               attack_q, attack_d;
    logic               flip_q, flip_d;
    logic               hit_q, hit_d;
    logic               busy_q, busy_d;
    logic               vsync_q;
    logic               mouse_q;

    logic               tick;
    logic               press;
    logic [SUM_W-1:0]   sum_out;

    // Rising-edge strobes: frame tick and button press, no added latency.
    always_comb begin
        tick    = vsync_in & ~vsync_q;
        press   = mouse_left & ~mouse_q;
        sum_out = {1'b0, offset_q} + SUM_W'(SWING_STEP);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            offset_q <= '0;
            cnt_q    <= '0;
            attack_q <= 1'b0;
            flip_q   <= 1'b0;
            hit_q    <= 1'b0;
            busy_q   <= 1'b0;
            vsync_q  <= 1'b0;
            mouse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            cnt_q    <= cnt_d;
            attack_q <= attack_d;
            flip_q   <= flip_d;
            hit_q    <= hit_d;
            busy_q   <= busy_d;
            vsync_q  <= vsync_in;
            mouse_q  <= mouse_left;
        end
    end

    // Next-state and next-output logic; everything holds between frame ticks.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        cnt_d    = cnt_q;
        attack_d = attack_q;
        flip_d   = flip_q;
        hit_d    = 1'b0;
        busy_d   = busy_q;

        case (state_q)
            IDLE: begin
                // A frame tick coinciding with the press is deliberately ignored.
                if (press) begin
                    state_d  = SWING_OUT;
                    attack_d = 1'b1;
                    busy_d   = 1'b1;
                    offset_d = '0;
                    flip_d   = flip_in;
                end
            end
            SWING_OUT: begin
                if (tick) begin
                    if (sum_out >= SUM_W'(SWING_MAX)) begin
                        offset_d = OFF_W'(SWING_MAX);
                        state_d  = SWING_BACK;
                        hit_d    = 1'b1;
                    end else begin
                        offset_d = sum_out[OFF_W-1:0];
                    end
                end
            end
            SWING_BACK: begin
                if (tick) begin
                    if (offset_q <= OFF_W'(SWING_STEP)) begin
                        offset_d = '0;
                        attack_d = 1'b0;
                        cnt_d    = CNT_W'(COOLDOWN_FRAMES);
                        if (COOLDOWN_FRAMES == 0) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = COOLDOWN;
                        end
                    end else begin
                        offset_d = offset_q - OFF_W'(SWING_STEP);
                    end
                end
            end
            COOLDOWN: begin
                // Presses here, including on the exit cycle, are dropped.
                if (tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        attack_active  = attack_q;
        anim_x_offset  = offset_q;
        flip_hor_melee = flip_q;
        hit_pulse      = hit_q;
        busy           = busy_q;
    end

endmodule

// File: tb/tb_melee_attack_ctl.sv
`timescale 1ns/1ps
// Scoreboard bench for melee_attack_ctl: stimulus pushes the expected output
// changes, a monitor pops one entry whenever the DUT outputs change.
module tb_melee_attack_ctl;

    localparam int GAP = 20;

    typedef struct {
        logic [15:0] v;
        int          dt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync_a, mouse_a, flip_a;
    logic        vsync_b, mouse_b, flip_b;
    logic        att_a, flip_o_a, hit_a, busy_a;
    logic        att_b, flip_o_b, hit_b, busy_b;
    logic [11:0] off_a, off_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    melee_attack_ctl u_dut_a (
        .clk(clk), .rst(rst), .vsync_in(vsync_a), .mouse_left(mouse_a), .flip_in(flip_a),
        .attack_active(att_a), .anim_x_offset(off_a), .flip_hor_melee(flip_o_a),
        .hit_pulse(hit_a), .busy(busy_a)
    );

    melee_attack_ctl #(.SWING_STEP(8), .SWING_MAX(24), .COOLDOWN_FRAMES(0)) u_dut_b (
        .clk(clk), .rst(rst), .vsync_in(vsync_b), .mouse_left(mouse_b), .flip_in(flip_b),
        .attack_active(att_b), .anim_x_offset(off_b), .flip_hor_melee(flip_o_b),
        .hit_pulse(hit_b), .busy(busy_b)
    );

    function automatic logic [15:0] pk(input logic att, input int off, input logic f,
                                       input logic hit, input logic bsy);
        logic [11:0] o;
        o = 12'(off);
        return {att, o, f, hit, bsy};
    endfunction

    task automatic push(input bit which, input logic att, input int off, input logic f,
                        input logic hit, input logic bsy, input int dt);
        exp_t e;
        e.v  = pk(att, off, f, hit, bsy);
        e.dt = dt;
        if (which) q_b.push_back(e);
        else       q_a.push_back(e);
    endtask

    // Monitor for DUT A: one scoreboard pop per observed output change.
    logic [15:0] prev_a;
    int          last_a = 0;
    always @(negedge clk) begin
        logic [15:0] cur;
        exp_t        e;
        cyc++;
        cur = {att_a, off_a, flip_o_a, hit_a, busy_a};
        if (mon_en && cur !== prev_a) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL dut_a_unexpected: got %h, no change expected", cur);
            end else begin
                e = q_a.pop_front();
                if (cur !== e.v || (e.dt != 0 && cyc - last_a != e.dt)) begin
                    errors++;
                    $display("FAIL dut_a_event: got %h after %0d cyc, expected %h after %0d cyc",
                             cur, cyc - last_a, e.v, e.dt);
                end
            end
            last_a = cyc;
        end
        prev_a = cur;
    end

    // Monitor for DUT B.
    logic [15:0] prev_b;
    int          last_b = 0;
    always @(negedge clk) begin
        logic [15:0] cur;
        exp_t        e;
        cur = {att_b, off_b, flip_o_b, hit_b, busy_b};
        if (mon_en && cur !== prev_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL dut_b_unexpected: got %h, no change expected", cur);
            end else begin
                e = q_b.pop_front();
                if (cur !== e.v || (e.dt != 0 && cyc - last_b != e.dt)) begin
                    errors++;
                    $display("FAIL dut_b_event: got %h after %0d cyc, expected %h after %0d cyc",
                             cur, cyc - last_b, e.v, e.dt);
                end
            end
            last_b = cyc;
        end
        prev_b = cur;
    end

    task automatic tick(input bit which);
        @(posedge clk);
        #1;
        if (which) vsync_b = 1'b1; else vsync_a = 1'b1;
        @(posedge clk);
        #1;
        if (which) vsync_b = 1'b0; else vsync_a = 1'b0;
        repeat (GAP) @(posedge clk);
    endtask

    // Press with expected swing start; optionally keep the button held.
    task automatic press(input bit which, input logic f, input bit hold);
        push(which, 1'b1, 0, f, 1'b0, 1'b1, 0);
        @(posedge clk);
        #1;
        if (which) begin flip_b = f; mouse_b = 1'b1; end
        else       begin flip_a = f; mouse_a = 1'b1; end
        repeat (2) @(posedge clk);
        #1;
        if (!hold) begin
            if (which) mouse_b = 1'b0; else mouse_a = 1'b0;
        end
    endtask

    // Ticks k0+1..k1 of DUT A's 22-tick attack (12 swing + 10 cooldown).
    task automatic swing_a(input logic f, input int k0, input int k1);
        for (int k = k0 + 1; k <= k1; k++) begin
            if (k <= 5)       push(1'b0, 1'b1, 4 * k, f, 1'b0, 1'b1, 0);
            else if (k == 6) begin
                push(1'b0, 1'b1, 24, f, 1'b1, 1'b1, 0);
                push(1'b0, 1'b1, 24, f, 1'b0, 1'b1, 1);
            end
            else if (k <= 11) push(1'b0, 1'b1, 4 * (12 - k), f, 1'b0, 1'b1, 0);
            else if (k == 12) push(1'b0, 1'b0, 0, f, 1'b0, 1'b1, 0);
            else if (k == 22) push(1'b0, 1'b0, 0, f, 1'b0, 1'b0, 0);
            tick(1'b0);
        end
    endtask

    // DUT B: step 8, max 24, no cooldown.
    task automatic swing_b(input logic f);
        for (int k = 1; k <= 6; k++) begin
            if (k <= 2)      push(1'b1, 1'b1, 8 * k, f, 1'b0, 1'b1, 0);
            else if (k == 3) begin
                push(1'b1, 1'b1, 24, f, 1'b1, 1'b1, 0);
                push(1'b1, 1'b1, 24, f, 1'b0, 1'b1, 1);
            end
            else if (k <= 5) push(1'b1, 1'b1, 8 * (6 - k), f, 1'b0, 1'b1, 0);
            else             push(1'b1, 1'b0, 0, f, 1'b0, 1'b0, 0);
            tick(1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        vsync_a = 1'b0; mouse_a = 1'b0; flip_a = 1'b0;
        vsync_b = 1'b0; mouse_b = 1'b0; flip_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({att_a, off_a, flip_o_a, hit_a, busy_a} !== 16'h0) begin
            errors++;
            $display("FAIL reset_a: got %h, expected 0000", {att_a, off_a, flip_o_a, hit_a, busy_a});
        end
        checks++;
        if ({att_b, off_b, flip_o_b, hit_b, busy_b} !== 16'h0) begin
            errors++;
            $display("FAIL reset_b: got %h, expected 0000", {att_b, off_b, flip_o_b, hit_b, busy_b});
        end
        mon_en = 1'b1;
        tick(1'b0);

        // 1: single press, full swing and cooldown.
        press(1'b0, 1'b0, 1'b0);
        swing_a(1'b0, 0, 22);

        // 2: held button gives one attack; press during cooldown is dropped.
        press(1'b0, 1'b0, 1'b1);
        swing_a(1'b0, 0, 22);
        for (int i = 0; i < 8; i++) tick(1'b0);
        #1 mouse_a = 1'b0;
        repeat (3) @(posedge clk);
        press(1'b0, 1'b0, 1'b0);
        swing_a(1'b0, 0, 15);
        @(posedge clk);
        #1 mouse_a = 1'b1;
        repeat (2) @(posedge clk);
        #1 mouse_a = 1'b0;
        swing_a(1'b0, 15, 22);
        press(1'b0, 1'b0, 1'b0);
        swing_a(1'b0, 0, 22);

        // 3: facing latched at start, mid-swing flip ignored.
        press(1'b0, 1'b1, 1'b0);
        swing_a(1'b1, 0, 3);
        #1 flip_a = 1'b0;
        swing_a(1'b1, 3, 22);
        press(1'b0, 1'b0, 1'b0);
        swing_a(1'b0, 0, 22);

        // 4: press and tick on the same cycle; tick is not applied.
        push(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 0);
        @(posedge clk);
        #1 begin mouse_a = 1'b1; vsync_a = 1'b1; flip_a = 1'b0; end
        @(posedge clk);
        #1 begin mouse_a = 1'b0; vsync_a = 1'b0; end
        repeat (GAP) @(posedge clk);
        swing_a(1'b0, 0, 22);

        // 5: reset at offset 16, then a clean restart.
        press(1'b0, 1'b1, 1'b0);
        swing_a(1'b1, 0, 4);
        push(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        tick(1'b0);
        press(1'b0, 1'b0, 1'b0);
        swing_a(1'b0, 0, 22);

        // 6: no cooldown, coarse step.
        press(1'b1, 1'b1, 1'b0);
        swing_b(1'b1);
        tick(1'b1);

        for (int i = 0; i < 500 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("FAIL dut_a_pending: got %0d unseen events, expected 0", q_a.size());
        end
        checks++;
        if (q_b.size() != 0) begin
            errors++;
            $display("FAIL dut_b_pending: got %0d unseen events, expected 0", q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
